alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one combinational 32-bit ALU, including its zero/negative/overflow/carry flag logic, between two requesters, such as the PC-increment path and the execute stage. The block arbitrates requests and registers operands onto the ALU inputs. It waits a programmable number of cycles for the gate-level ripple to settle, captures the result and flags, and returns them over a valid/ready response channel. It sits between the control unit and the ALU instance in the single-ALU datapath.

## Interface
- WIDTH, 32, operand/result width
- SETTLE_CYCLES, 4, cycles the ALU inputs are held before capture; legal range 1–255

- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  2  per-requester request valid; bit 0 is requester 0
- req_ready  output  2  per-requester accept; combinational, one-hot or zero
- req_a0, req_b0  input  WIDTH each  requester 0 operands
- req_op0  input  3  requester 0 ALU control code
- req_a1, req_b1  input  WIDTH each  requester 1 operands
- req_op1  input  3  requester 1 ALU control code
- alu_a, alu_b  output  WIDTH each  registered ALU operands
- alu_cntrl  output  3  registered ALU control
- alu_result  input  WIDTH  ALU result
- alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1 each  ALU flags
- resp_valid  output  1  response valid
- resp_ready  input  1  response accept
- resp_id  output  1  requester that owns the response
- resp_result  output  WIDTH  captured result
- resp_negative, resp_zero, resp_overflow, resp_carry  output  1 each  captured flags
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - If any req_valid bit is set, the grant g is chosen by policy and req_ready[g]=1 combinationally. req_ready is 0 in every other state.
  - On the clock edge with req_valid[g] & req_ready[g], the block latches a/b/op into alu_a/alu_b/alu_cntrl and records resp_id=g.
  - In the same edge it loads the settle counter with SETTLE_CYCLES-1 and moves to SETTLE.
- SETTLE:
  - The counter decrements each cycle.
  - On the edge where the counter is 0, the block registers alu_result and all four flags into resp_* and moves to RESP.
- RESP:
  - resp_valid=1 and all resp_* outputs are held stable.
  - On the edge with resp_valid & resp_ready, the block returns to IDLE and resp_valid falls.
- alu_a, alu_b and alu_cntrl are unchanged from accept until the next accept. They are not cleared on return to IDLE.
- Op codes pass through to the ALU unmodified, including unused codes; the block does no decoding.
- Round-robin policy: a priority pointer names the preferred requester.
  - When both requesters are valid in IDLE, the preferred requester wins.
  - After every grant the pointer moves to the other requester.
  - A lone valid requester always wins, regardless of the pointer.
- If a requester drops req_valid while not granted, nothing happens; there is no pending state.
- Only one transaction is in flight at a time. No request is accepted while in SETTLE or RESP.

## Timing
- Reset (asynchronous):
  - State goes to IDLE and the counter to 0.
  - alu_a, alu_b, resp_result go to 0; alu_cntrl goes to 3'b000; all flag outputs, resp_valid, resp_id and busy go to 0.
  - The priority pointer is set to requester 0.
- Reset asserted mid-transaction aborts the transaction with no response. After reset releases, the first IDLE cycle arbitrates normally.
- Latency: with accept at edge T, resp_valid rises at edge T+SETTLE_CYCLES.
- If resp_ready is already high, the earliest next accept is edge T+SETTLE_CYCLES+2. Minimum period per operation is SETTLE_CYCLES+2 cycles.
- With SETTLE_CYCLES=1, capture occurs at the first edge after accept.
- Counter wrap is impossible: the counter is only decremented while nonzero, and capture happens at 0.
- A resp_ready level in IDLE or SETTLE is ignored.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: fixed priority. Requester 0 always wins when both are valid, and the pointer logic is removed.
  - Undefined (default): round-robin as described under Operation.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Reset with SETTLE_CYCLES=4: all outputs 0 and busy=0. Then requester 0 with a=5, b=5, op=011 (subtract) is accepted. resp_valid rises 4 edges after accept with resp_id=0, and resp_zero reflects a zero result from the ALU model (resp_result=0, resp_zero=1).
- Both requesters valid continuously and resp_ready=1: grants alternate 0,1,0,1; ALU_ARB_FIXED_PRIO_EN build gives 0,0,0.
- resp_ready held low for 10 cycles after resp_valid: resp_* stable, req_ready stays 0 although req_valid[1]=1; accept of requester 1 occurs only after the response handshake.
- Requester 1 sends a=0x7FFFFFFF, b=1, op=010 (add): resp_overflow=1, resp_negative=1, resp_zero=0, resp_carry=0.
- reset pulsed during SETTLE: resp_valid never rises and the state returns to IDLE. The next request from requester 1 completes with correct latency, and the pointer prefers 0 again.
- SETTLE_CYCLES=1 back-to-back requests with resp_ready=1: one operation completes every 3 cycles.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter feeding one shared combinational ALU
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins (no round-robin pointer).
module alu_share_arbiter #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [2:0]       req_op0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [2:0]       req_op1,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cntrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_negative,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   input  logic             alu_carry_out,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_negative,
   output logic             resp_zero,
   output logic             resp_overflow,
   output logic             resp_carry,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt;
   logic       grant;
   logic       accept;
   logic       capture;

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant = ~req_valid[0];
   end
`else
   logic ptr;

   // Preferred requester wins a tie; a lone requester wins regardless.
   always_comb begin
      if (&req_valid) grant = ptr;
      else            grant = req_valid[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       ptr <= 1'b0;
      else if (accept) ptr <= ~grant;
   end
`endif

   assign accept  = (state == IDLE) && (|req_valid);
   assign capture = (state == SETTLE) && (cnt == 8'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETTLE;
         SETTLE:  if (capture) state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 2'b00;
      if (accept) req_ready = grant ? 2'b10 : 2'b01;
      resp_valid = (state == RESP);
      busy       = (state != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt           <= 8'd0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_cntrl     <= 3'b000;
         resp_id       <= 1'b0;
         resp_result   <= '0;
         resp_negative <= 1'b0;
         resp_zero     <= 1'b0;
         resp_overflow <= 1'b0;
         resp_carry    <= 1'b0;
      end else begin
         if (accept) begin
            alu_a     <= grant ? req_a1 : req_a0;
            alu_b     <= grant ? req_b1 : req_b0;
            alu_cntrl <= grant ? req_op1 : req_op0;
            resp_id   <= grant;
            cnt       <= 8'(SETTLE_CYCLES - 1);
         end else if (state == SETTLE && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
         if (capture) begin
            resp_result   <= alu_result;
            resp_negative <= alu_negative;
            resp_zero     <= alu_zero;
            resp_overflow <= alu_overflow;
            resp_carry    <= alu_carry_out;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   always #5 clk = ~clk;

   // main instance, SETTLE_CYCLES=4
   logic [1:0]  req_valid = 2'b00, req_ready;
   logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
   logic [2:0]  req_op0 = '0, req_op1 = '0;
   logic [31:0] alu_a, alu_b, alu_result, resp_result;
   logic [2:0]  alu_cntrl;
   logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
   logic        resp_valid, resp_ready = 1'b0, resp_id;
   logic        resp_negative, resp_zero, resp_overflow, resp_carry, busy;

   // second instance, SETTLE_CYCLES=1
   logic [1:0]  d1_req_valid = 2'b00, d1_req_ready;
   logic [31:0] d1_alu_a, d1_alu_b, d1_alu_result, d1_resp_result;
   logic [2:0]  d1_alu_cntrl;
   logic        d1_n, d1_z, d1_v, d1_c;
   logic        d1_resp_valid, d1_resp_id, d1_rn, d1_rz, d1_rv, d1_rc, d1_busy;

   int errors = 0;
   int checks = 0;

   function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      c = 1'b0; v = 1'b0;
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  begin s = {1'b0, a} + {1'b0, b};  r = s[31:0]; c = s[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
         3'b011:  begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                        v = (a[31] != b[31]) && (r[31] != a[31]); end
         default: r = a ^ b;
      endcase
      return {r[31], (r == 32'd0), v, c, r};
   endfunction

   always_comb {alu_negative, alu_zero, alu_overflow, alu_carry_out, alu_result} =
      alu_model(alu_a, alu_b, alu_cntrl);
   always_comb {d1_n, d1_z, d1_v, d1_c, d1_alu_result} = alu_model(d1_alu_a, d1_alu_b, d1_alu_cntrl);

   alu_share_arbiter #(.WIDTH(32), .SETTLE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
      .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_result(alu_result),
      .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .alu_carry_out(alu_carry_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_result(resp_result), .resp_negative(resp_negative),
      .resp_zero(resp_zero), .resp_overflow(resp_overflow), .resp_carry(resp_carry),
      .busy(busy)
   );

   alu_share_arbiter #(.WIDTH(32), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(d1_req_valid), .req_ready(d1_req_ready),
      .req_a0(32'd10), .req_b0(32'd3), .req_op0(3'b011),
      .req_a1(32'd0), .req_b1(32'd0), .req_op1(3'b000),
      .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_cntrl(d1_alu_cntrl), .alu_result(d1_alu_result),
      .alu_negative(d1_n), .alu_zero(d1_z), .alu_overflow(d1_v), .alu_carry_out(d1_c),
      .resp_valid(d1_resp_valid), .resp_ready(1'b1), .resp_id(d1_resp_id),
      .resp_result(d1_resp_result), .resp_negative(d1_rn), .resp_zero(d1_rz),
      .resp_overflow(d1_rv), .resp_carry(d1_rc), .busy(d1_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Call right after the accept edge; counts edges until resp_valid rises.
   task automatic wait_resp(output int n);
      n = 0;
      while (!resp_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   logic [1:0]  exp_grant [4];
   int          gid [4];
   int          gcyc [4];
   int          d1cyc [3];
   int          n, g, k;
   logic [35:0] snap;
   logic        stable, rdy_zero, seen;
   logic [31:0] d1_last;

   initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_grant = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp_grant = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
      #1 reset = 1'b1;
      #10;
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_outputs", {alu_a, alu_b, alu_cntrl, resp_id}, 0);
      check("rst_resp", {resp_result, resp_negative, resp_zero, resp_overflow, resp_carry}, 0);
      check("rst_req_ready", req_ready, 2'b00);
      @(negedge clk) reset = 1'b0;
      tick();

      // requester 0: 5 - 5
      req_a0 = 32'd5; req_b0 = 32'd5; req_op0 = 3'b011; req_valid = 2'b01;
      #1 check("r0_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      check("r0_busy", busy, 1);
      check("r0_alu_in", {alu_a, alu_b, alu_cntrl}, {32'd5, 32'd5, 3'b011});
      wait_resp(n);
      check("r0_latency", n, 4);
      check("r0_resp", {resp_id, resp_result, resp_zero, resp_negative}, {1'b0, 32'd0, 1'b1, 1'b0});

      // stall the response while requester 1 waits
      req_a1 = 32'h7FFF_FFFF; req_b1 = 32'd1; req_op1 = 3'b010; req_valid = 2'b10;
      snap = {resp_negative, resp_zero, resp_overflow, resp_carry, resp_result};
      stable = 1'b1; rdy_zero = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if ({resp_negative, resp_zero, resp_overflow, resp_carry, resp_result} !== snap
             || !resp_valid || resp_id !== 1'b0) stable = 1'b0;
         if (req_ready !== 2'b00) rdy_zero = 1'b0;
      end
      check("stall_resp_stable", stable, 1);
      check("stall_req_ready_zero", rdy_zero, 1);
      resp_ready = 1'b1;
      tick();
      check("hs_resp_valid_fall", resp_valid, 0);
      check("hs_r1_ready", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      check("r1_alu_in", {alu_a, alu_b, alu_cntrl}, {32'h7FFF_FFFF, 32'd1, 3'b010});
      wait_resp(n);
      check("r1_latency", n, 4);
      check("r1_resp", {resp_id, resp_result}, {1'b1, 32'h8000_0000});
      check("r1_flags", {resp_overflow, resp_negative, resp_zero, resp_carry}, 4'b1100);
      tick();

      // both requesters continuously valid
      req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = 3'b001;
      req_a1 = 32'd3; req_b1 = 32'd4; req_op1 = 3'b000;
      req_valid = 2'b11;
      #1 g = 0;
      for (int c = 0; c < 100 && g < 4; c++) begin
         if (req_ready != 2'b00) begin
            gid[g] = int'(req_ready[1]);
            gcyc[g] = c;
            g++;
         end
         tick();
      end
      req_valid = 2'b00;
      check("rr_grant_count", g, 4);
      for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), gid[i], exp_grant[i]);
      check("rr_period", gcyc[3] - gcyc[2], 6);
      k = 0;
      while (busy && k < 50) begin tick(); k++; end
      check("rr_drain", busy, 0);

      // reset pulsed mid-transaction
      req_a0 = 32'd9; req_b0 = 32'd1; req_op0 = 3'b010; req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick(); tick();
      #2 reset = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_alu_a", alu_a, 0);
      tick();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (resp_valid || busy) seen = 1'b1;
      end
      check("arst_no_resp", seen, 0);
      req_valid = 2'b11;
      #1 check("arst_ptr_prefers0", req_ready, 2'b01);
      req_a1 = 32'd20; req_b1 = 32'd22; req_op1 = 3'b010; req_valid = 2'b10;
      #1 check("arst_r1_ready", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      wait_resp(n);
      check("arst_r1_latency", n, 4);
      check("arst_r1_resp", {resp_id, resp_result}, {1'b1, 32'd42});
      tick();

      // SETTLE_CYCLES=1 back-to-back
      d1_req_valid = 2'b01;
      #1 g = 0;
      d1_last = 32'hDEAD_BEEF;
      for (int c = 0; c < 60 && g < 3; c++) begin
         if (d1_req_ready != 2'b00) begin
            d1cyc[g] = c;
            g++;
         end
         if (d1_resp_valid) d1_last = d1_resp_result;
         tick();
      end
      d1_req_valid = 2'b00;
      check("s1_accept_count", g, 3);
      check("s1_period_a", d1cyc[1] - d1cyc[0], 3);
      check("s1_period_b", d1cyc[2] - d1cyc[1], 3);
      check("s1_result", d1_last, 32'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
